// File: rtl/adex_u_update_tdm_pkg.sv
// -----------------------------------------------------------------------------
// adex_pkg
// Shared types and helpers for the AdEx adaptation-current engine and the
// membrane-potential integrator that sits beside it.
//   adex_u_state_t : sweep controller states
//   DATA_W_DEF     : default signed data width of v / u / dt
//   FRAC_W_DEF     : default number of fractional bits
//   sat_narrow     : clamp a wide signed value into a w-bit signed range
// -----------------------------------------------------------------------------
package adex_pkg;

   localparam int DATA_W_DEF = 16;
   localparam int FRAC_W_DEF = 12;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      CALC,
      WRITE,
      DONE
   } adex_u_state_t;

   // Returns x clamped to [-2^(w-1), 2^(w-1)-1], still 64 bits wide so the
   // caller picks the low w bits. Callers sign-extend their accumulator to 64.
   function automatic logic signed [63:0] sat_narrow(input logic signed [63:0] x,
                                                     input int w);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      if (x > hi) begin
         return hi;
      end
      if (x < lo) begin
         return lo;
      end
      return x;
   endfunction

endpackage

// File: rtl/adex_u_update_tdm_if.sv
// -----------------------------------------------------------------------------
// adex_u_update_tdm_if
// Bundles the control, v read-port and u result-stream signals of the
// adaptation engine.
//   master : the side that drives start/u_clr/dt/spike_vec and serves v reads
//   slave  : the adaptation engine itself
// Signals: start, u_clr, dt, spike_vec (requests); v_addr, v_rd_en, v_rd_data
// (v read port, 1-cycle latency); u_valid, u_idx, u_out (result stream);
// busy, done (status).
// -----------------------------------------------------------------------------
interface adex_u_update_tdm_if #(
   parameter int N_NEURONS = 16,
   parameter int DATA_W    = 16
);
   localparam int AW = $clog2(N_NEURONS);

   logic                     start;
   logic                     u_clr;
   logic signed [DATA_W-1:0] dt;
   logic [N_NEURONS-1:0]     spike_vec;
   logic [AW-1:0]            v_addr;
   logic                     v_rd_en;
   logic signed [DATA_W-1:0] v_rd_data;
   logic                     u_valid;
   logic [AW-1:0]            u_idx;
   logic signed [DATA_W-1:0] u_out;
   logic                     busy;
   logic                     done;

   modport master (
      output start, u_clr, dt, spike_vec, v_rd_data,
      input  v_addr, v_rd_en, u_valid, u_idx, u_out, busy, done
   );

   modport slave (
      input  start, u_clr, dt, spike_vec, v_rd_data,
      output v_addr, v_rd_en, u_valid, u_idx, u_out, busy, done
   );

endinterface

// File: rtl/adex_u_update_tdm_datapath.sv
// -----------------------------------------------------------------------------
// adex_u_datapath
// Purely combinational Euler step for one neuron's adaptation current:
//   diff   = ((A_COEF * (v - E_L)) >>> FRAC_W) - u
//   u_next = u + ((dt * diff) >>> FRAC_W) + (spike ? B_INC : 0)
//   u_sat  = u_next clamped to the signed DATA_W range
// Ports:
//   v_i, u_i, dt_i : signed DATA_W operands
//   spike_i        : spike flag of this neuron
//   u_sat_o        : saturated result
// -----------------------------------------------------------------------------
module adex_u_datapath
   import adex_pkg::*;
#(
   parameter int                       DATA_W = DATA_W_DEF,
   parameter int                       FRAC_W = FRAC_W_DEF,
   parameter logic signed [DATA_W-1:0] A_COEF = 16'sd2,
   parameter logic signed [DATA_W-1:0] B_INC  = 16'sd100,
   parameter logic signed [DATA_W-1:0] E_L    = -16'sd70
) (
   input  logic signed [DATA_W-1:0] v_i,
   input  logic signed [DATA_W-1:0] u_i,
   input  logic signed [DATA_W-1:0] dt_i,
   input  logic                     spike_i,
   output logic signed [DATA_W-1:0] u_sat_o
);

   // Wide enough that neither product nor the running sums can wrap.
   localparam int ACC_W = 2 * DATA_W + 8;

   logic signed [DATA_W:0]   v_rel;
   logic signed [ACC_W-1:0]  v_rel_x;
   logic signed [ACC_W-1:0]  u_x;
   logic signed [ACC_W-1:0]  dt_x;
   logic signed [ACC_W-1:0]  a_x;
   logic signed [ACC_W-1:0]  b_add;
   logic signed [ACC_W-1:0]  diff;
   logic signed [ACC_W-1:0]  du;
   logic signed [ACC_W-1:0]  u_next;
   logic signed [63:0]       u_next_wide;

   always_comb begin
      // One extra bit so v - E_L never wraps.
      v_rel       = {v_i[DATA_W-1], v_i} - {E_L[DATA_W-1], E_L};
      v_rel_x     = {{(ACC_W-DATA_W-1){v_rel[DATA_W]}}, v_rel};
      u_x         = {{(ACC_W-DATA_W){u_i[DATA_W-1]}}, u_i};
      dt_x        = {{(ACC_W-DATA_W){dt_i[DATA_W-1]}}, dt_i};
      a_x         = {{(ACC_W-DATA_W){A_COEF[DATA_W-1]}}, A_COEF};
      b_add       = '0;
      if (spike_i) begin
         b_add = {{(ACC_W-DATA_W){B_INC[DATA_W-1]}}, B_INC};
      end
      diff        = ((a_x * v_rel_x) >>> FRAC_W) - u_x;
      du          = (dt_x * diff) >>> FRAC_W;
      u_next      = u_x + du + b_add;
      u_next_wide = {{(64-ACC_W){u_next[ACC_W-1]}}, u_next};
      u_sat_o     = DATA_W'(sat_narrow(u_next_wide, DATA_W));
   end

endmodule

// File: rtl/adex_u_update_tdm.sv
// -----------------------------------------------------------------------------
// adex_u_update_tdm
// Time-multiplexed adaptation-current engine. Keeps u for N_NEURONS neurons in
// a register file and, per accepted start, sweeps them in ascending order with
// three cycles per neuron (FETCH, CALC, WRITE).
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset (also clears every stored u)
//   bus  : slave side of adex_u_update_tdm_if (start/u_clr/dt/spike_vec in,
//          v read port, u result stream, busy/done status)
// -----------------------------------------------------------------------------
module adex_u_update_tdm
   import adex_pkg::*;
#(
   parameter int                       N_NEURONS = 16,
   parameter int                       DATA_W    = DATA_W_DEF,
   parameter int                       FRAC_W    = FRAC_W_DEF,
   parameter logic signed [DATA_W-1:0] A_COEF    = 16'sd2,
   parameter logic signed [DATA_W-1:0] B_INC     = 16'sd100,
   parameter logic signed [DATA_W-1:0] E_L       = -16'sd70
) (
   input logic                  clk,
   input logic                  rst,
   adex_u_update_tdm_if.slave   bus
);

   localparam int            AW       = $clog2(N_NEURONS);
   localparam logic [AW-1:0] LAST_IDX = AW'(N_NEURONS - 1);

   adex_u_state_t            state_q, state_d;
   logic [AW-1:0]            idx_q, idx_d;
   logic signed [DATA_W-1:0] dt_q;
   logic [N_NEURONS-1:0]     spike_q;
   logic signed [DATA_W-1:0] u_hold_q;
   logic signed [DATA_W-1:0] u_mem_q [N_NEURONS];
   logic                     u_valid_q;
   logic [AW-1:0]            u_idx_q;
   logic signed [DATA_W-1:0] u_out_q;
   logic signed [DATA_W-1:0] u_sat;
   logic                     accept;
   logic                     clr_req;
   logic [N_NEURONS-1:0]     wr_en;

   // Clear has priority over start when both arrive in IDLE.
   assign clr_req = (state_q == IDLE) && bus.u_clr;
   assign accept  = (state_q == IDLE) && bus.start && !bus.u_clr;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = FETCH;
               idx_d   = '0;
            end
         end
         FETCH: state_d = CALC;
         CALC:  state_d = WRITE;
         WRITE: begin
            if (idx_q == LAST_IDX) begin
               state_d = DONE;
            end else begin
               idx_d   = idx_q + 1'b1;
               state_d = FETCH;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // The read data arrives during CALC and feeds the datapath directly; its
   // result is registered at the CALC->WRITE edge so the u_valid strobe lines
   // up with the WRITE cycle and the register file is written from u_out_q.
   adex_u_datapath #(
      .DATA_W (DATA_W),
      .FRAC_W (FRAC_W),
      .A_COEF (A_COEF),
      .B_INC  (B_INC),
      .E_L    (E_L)
   ) u_datapath (
      .v_i     (bus.v_rd_data),
      .u_i     (u_hold_q),
      .dt_i    (dt_q),
      .spike_i (spike_q[idx_q]),
      .u_sat_o (u_sat)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         dt_q      <= '0;
         spike_q   <= '0;
         u_hold_q  <= '0;
         u_valid_q <= 1'b0;
         u_idx_q   <= '0;
         u_out_q   <= '0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         u_valid_q <= (state_q == CALC);
         if (accept) begin
            dt_q    <= bus.dt;
            spike_q <= bus.spike_vec;
         end
         if (state_q == FETCH) begin
            u_hold_q <= u_mem_q[idx_q];
         end
         if (state_q == CALC) begin
            u_out_q <= u_sat;
            u_idx_q <= idx_q;
         end
      end
   end

   for (genvar gi = 0; gi < N_NEURONS; gi++) begin : g_wr_en
      assign wr_en[gi] = (state_q == WRITE) && (idx_q == AW'(gi));
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < N_NEURONS; i++) begin
         if (rst || clr_req) begin
            u_mem_q[i] <= '0;
         end else if (wr_en[i]) begin
            u_mem_q[i] <= u_out_q;
         end
      end
   end

   assign bus.v_addr  = idx_q;
   assign bus.v_rd_en = (state_q == FETCH);
   assign bus.u_valid = u_valid_q;
   assign bus.u_idx   = u_idx_q;
   assign bus.u_out   = u_out_q;
   assign bus.busy    = (state_q != IDLE);
   assign bus.done    = (state_q == DONE);

endmodule

// File: tb/tb_adex_u_update_tdm.sv
// -----------------------------------------------------------------------------
// tb_adex_u_update_tdm
// Directed bench for adex_u_update_tdm: a default-parameter instance exercised
// over rest, spike/decay, clear, drive, start-while-busy and reset-abort
// sweeps, plus a B_INC = 20000 instance for output saturation.
// -----------------------------------------------------------------------------
module tb_adex_u_update_tdm;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   adex_u_update_tdm_if #(.N_NEURONS(16), .DATA_W(16)) bus ();
   adex_u_update_tdm_if #(.N_NEURONS(16), .DATA_W(16)) bus2 ();

   adex_u_update_tdm dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   adex_u_update_tdm #(.B_INC(16'sd20000)) dut_sat (
      .clk (clk),
      .rst (rst),
      .bus (bus2)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic signed [15:0] v_mem [16];
   logic signed [15:0] exp_u [16];

   // Monitor records for the default instance.
   int                 vcnt     = 0;
   int                 vidx [1024];
   logic signed [15:0] vval [1024];
   int                 vcyc [1024];
   int                 done_cnt = 0;
   int                 done_cyc = 0;

   // Monitor records for the saturating instance.
   logic signed [15:0] u5_val    = '0;
   int                 done2_cnt = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // v memory model: one-cycle read latency for both instances.
   always @(posedge clk) begin
      if (bus.v_rd_en)  bus.v_rd_data  <= v_mem[bus.v_addr];
      if (bus2.v_rd_en) bus2.v_rd_data <= v_mem[bus2.v_addr];
   end

   always @(negedge clk) begin
      if (bus.u_valid === 1'b1) begin
         if (vcnt < 1024) begin
            vidx[vcnt] = int'(bus.u_idx);
            vval[vcnt] = bus.u_out;
            vcyc[vcnt] = cyc;
         end
         vcnt++;
      end
      if (bus.done === 1'b1) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (bus2.u_valid === 1'b1 && bus2.u_idx == 4'd5) u5_val = bus2.u_out;
      if (bus2.done === 1'b1) done2_cnt++;
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic signed [63:0] got,
                      input logic signed [63:0] want);
      total++;
      assert (got === want) else begin
         bad++;
         $error("FAIL %s: got=%0d expected=%0d", tag, got, want);
      end
   endtask

   task automatic set_exp_all(input logic signed [15:0] val);
      for (int i = 0; i < 16; i++) exp_u[i] = val;
   endtask

   // Runs one sweep on the default instance; mid >= 1 re-pulses start that
   // many cycles into the sweep.
   task automatic sweep(input logic signed [15:0] dtv, input logic [15:0] spk,
                        input int mid, output int base);
      int dbase;
      int s0;
      int n;
      base  = vcnt;
      dbase = done_cnt;
      bus.dt        = dtv;
      bus.spike_vec = spk;
      bus.start     = 1'b1;
      s0 = cyc;
      tick();
      bus.start = 1'b0;
      n = 1;
      while (done_cnt == dbase && n < 200) begin
         if (n == mid) bus.start = 1'b1;
         tick();
         bus.start = 1'b0;
         n++;
      end
      chk("done_seen", done_cnt - dbase, 1);
      chk("done_latency", done_cyc - s0, 49);
      chk("first_valid_latency", vcyc[base] - s0, 3);
      tick();
      chk("done_one_cycle", bus.done, 0);
   endtask

   task automatic check_sweep(input string tag, input int base);
      chk({tag, "_count"}, vcnt - base, 16);
      for (int i = 0; i < 16; i++) begin
         chk($sformatf("%s_idx%0d", tag, i), vidx[base+i], i);
         chk($sformatf("%s_u%0d", tag, i), vval[base+i], exp_u[i]);
         if (i > 0) chk($sformatf("%s_gap%0d", tag, i), vcyc[base+i] - vcyc[base+i-1], 3);
      end
   endtask

   task automatic sweep_sat(input string tag, input logic signed [15:0] want);
      int dbase;
      int n;
      dbase = done2_cnt;
      bus2.dt        = 16'sd0;
      bus2.spike_vec = 16'h0020;
      bus2.start     = 1'b1;
      tick();
      bus2.start = 1'b0;
      n = 0;
      while (done2_cnt == dbase && n < 200) begin
         tick();
         n++;
      end
      chk({tag, "_done"}, done2_cnt - dbase, 1);
      chk({tag, "_u5"}, u5_val, want);
      tick();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int b;
      int dbase;
      int n;
      int busy_seen;

      for (int i = 0; i < 16; i++) v_mem[i] = -16'sd70;
      rst = 1'b1;
      bus.start  = 1'b0;  bus.u_clr  = 1'b0; bus.dt  = '0; bus.spike_vec  = '0;
      bus2.start = 1'b0;  bus2.u_clr = 1'b0; bus2.dt = '0; bus2.spike_vec = '0;
      repeat (3) tick();

      // Reset state.
      chk("rst_busy",    bus.busy,    0);
      chk("rst_done",    bus.done,    0);
      chk("rst_u_valid", bus.u_valid, 0);
      chk("rst_v_rd_en", bus.v_rd_en, 0);
      chk("rst_v_addr",  bus.v_addr,  0);
      chk("rst_u_idx",   bus.u_idx,   0);
      chk("rst_u_out",   bus.u_out,   0);
      rst = 1'b0;
      tick();

      // Rest: v = E_L everywhere, no spikes.
      sweep(16'sd4096, 16'h0000, -1, b);
      set_exp_all(0);
      check_sweep("rest", b);

      // Spike on neuron 3, then decay back to 0.
      sweep(16'sd4096, 16'h0008, -1, b);
      set_exp_all(0); exp_u[3] = 16'sd100;
      check_sweep("spike", b);
      sweep(16'sd4096, 16'h0000, -1, b);
      set_exp_all(0);
      check_sweep("decay", b);

      // u_clr alone in IDLE; dt = 0 keeps any surviving u unchanged.
      sweep(16'sd4096, 16'h0008, -1, b);
      set_exp_all(0); exp_u[3] = 16'sd100;
      check_sweep("spike2", b);
      bus.u_clr = 1'b1;
      tick();
      bus.u_clr = 1'b0;
      sweep(16'sd0, 16'h0000, -1, b);
      set_exp_all(0);
      check_sweep("after_clr", b);

      // u_clr together with start: clears, no sweep.
      sweep(16'sd4096, 16'h0008, -1, b);
      set_exp_all(0); exp_u[3] = 16'sd100;
      check_sweep("spike3", b);
      b = vcnt;
      bus.u_clr = 1'b1;
      bus.start = 1'b1;
      tick();
      bus.u_clr = 1'b0;
      bus.start = 1'b0;
      busy_seen = 0;
      repeat (10) begin
         tick();
         if (bus.busy !== 1'b0) busy_seen = 1;
      end
      chk("clr_start_busy", busy_seen, 0);
      chk("clr_start_valids", vcnt - b, 0);
      sweep(16'sd0, 16'h0000, -1, b);
      set_exp_all(0);
      check_sweep("after_clr_start", b);

      // Drive: v = 2000 on neuron 0 -> 2*2070 >>> 12 = 1.
      v_mem[0] = 16'sd2000;
      sweep(16'sd4096, 16'h0000, -1, b);
      set_exp_all(0); exp_u[0] = 16'sd1;
      check_sweep("drive", b);
      v_mem[0] = -16'sd70;

      // Start while busy is ignored; u0 decays 1 -> 0.
      dbase = done_cnt;
      sweep(16'sd4096, 16'h0000, 10, b);
      set_exp_all(0);
      check_sweep("busy_start", b);
      repeat (60) tick();
      chk("busy_start_total_valids", vcnt - b, 16);
      chk("busy_start_total_done", done_cnt - dbase, 1);

      // Saturation instance: 0 + 20000, then 20000 + 20000 -> 32767.
      sweep_sat("sat1", 16'sd20000);
      sweep_sat("sat2", 16'sd32767);

      // Reset during a sweep: all neurons at 100 first.
      sweep(16'sd4096, 16'hFFFF, -1, b);
      set_exp_all(16'sd100);
      check_sweep("all_spike", b);
      b     = vcnt;
      dbase = done_cnt;
      bus.dt        = 16'sd0;
      bus.spike_vec = 16'h0000;
      bus.start     = 1'b1;
      tick();
      bus.start = 1'b0;
      n = 0;
      while (vcnt - b < 7 && n < 100) begin
         tick();
         n++;
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      repeat (60) tick();
      chk("abort_valids", vcnt - b, 7);
      chk("abort_done", done_cnt - dbase, 0);
      chk("abort_busy", bus.busy, 0);
      sweep(16'sd0, 16'h0000, -1, b);
      set_exp_all(0);
      check_sweep("after_rst", b);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/adex_u_update_tdm.md
# adex_u_update_tdm

Time-multiplexed adaptation-current engine for an array of AdEx neurons. It holds the adaptation current `u` of `N_NEURONS` neurons in an internal register file. On each `start` it sweeps every neuron once, applying one Euler step of `du = a·(v − E_L) − u` plus the spike-triggered increment `b`, with output saturation. It sits beside the membrane-potential integrator: it reads `v` through a one-cycle-latency read port and streams updated `u` values back to the integrator.

## Interface
Parameters:
- `N_NEURONS`, 16 — neurons handled per sweep (≥ 2).
- `DATA_W`, 16 — signed width of `v`, `u`, `dt`.
- `FRAC_W`, 12 — fractional bits; every product is shifted right arithmetically by `FRAC_W`.
- `A_COEF`, 16'sd2 — adaptation coupling `a`, signed `DATA_W`.
- `B_INC`, 16'sd100 — spike-triggered increment `b`, signed `DATA_W`.
- `E_L`, -16'sd70 — leak reversal potential, signed `DATA_W`.

Ports:
- `clk` in 1 — clock. Everything is on the rising edge.
- `rst` in 1 — reset. Synchronous, active-high.
- `start` in 1 — one-cycle request to begin a sweep.
- `u_clr` in 1 — clears all stored `u` to 0. Accepted in IDLE only.
- `dt` in `DATA_W` signed — time step, sampled on accepted `start`.
- `spike_vec` in `N_NEURONS` — per-neuron spike flags, sampled on accepted `start`.
- `v_addr` out `clog2(N_NEURONS)` — neuron index for the `v` read.
- `v_rd_en` out 1 — `v` read strobe.
- `v_rd_data` in `DATA_W` signed — `v` of `v_addr`, valid the cycle after `v_rd_en`.
- `u_valid` out 1 — one-cycle strobe marking an updated `u`.
- `u_idx` out `clog2(N_NEURONS)` — index of the updated neuron.
- `u_out` out `DATA_W` signed — updated, saturated `u`.
- `busy` out 1 — high from the cycle after an accepted `start` through DONE.
- `done` out 1 — one-cycle pulse at sweep end.

## Operation
State machine: IDLE → FETCH → CALC → WRITE → (FETCH for the next index | DONE) → IDLE.
- **IDLE**
  - `start` high is accepted: latch `dt` and `spike_vec`, set index to 0, go to FETCH.
  - `u_clr` in IDLE with `start` low: zero all `u` entries in one cycle.
  - `u_clr` and `start` both high: `u_clr` wins, `start` is dropped.
- **FETCH**: drive `v_addr` = index and `v_rd_en` = 1. Read `u[index]` into a holding register.
- **CALC**: register `v_rd_data`. Compute `diff = ((A_COEF·(v − E_L)) >>> FRAC_W) − u`.
- **WRITE**
  - Compute `u_next = u + ((dt·diff) >>> FRAC_W) + (spike ? B_INC : 0)`.
  - Saturate `u_next` to [−2^(DATA_W−1), 2^(DATA_W−1)−1] and write it to `u[index]`.
  - Pulse `u_valid`, with `u_idx` = index and `u_out` = the saturated value.
  - If index = `N_NEURONS`−1, go to DONE. Otherwise increment the index and go to FETCH.
- **DONE**: pulse `done`, return to IDLE.
- `start` outside IDLE is ignored. A new `start` is not queued.
- Width rules:
  - `v − E_L` is `DATA_W`+1 bits.
  - Products and the `diff`/`u_next` accumulators are at least 2·`DATA_W`+4 bits signed, so there is no intermediate overflow.
  - Saturation happens only at the final write.
- `u_out`, `u_idx` and `u_valid` are registered outputs.

## Timing
- Reset values:
  - State is IDLE.
  - All `u` entries are 0.
  - `busy`, `done`, `u_valid` and `v_rd_en` are 0.
  - `v_addr`, `u_idx` and `u_out` are 0.
- Per-neuron cost is 3 cycles (FETCH, CALC, WRITE).
- Sweep timing from the cycle `start` is sampled:
  - First `v_rd_en` one cycle later.
  - First `u_valid` three cycles later.
  - `done` at 3·`N_NEURONS`+1 cycles.
- `u_valid` strobes are spaced exactly 3 cycles apart and arrive in ascending index order.
- `start` may be asserted again in the cycle after `done`.
- `rst` mid-sweep:
  - Aborts the sweep next edge. No further `u_valid` or `done`.
  - All `u` entries are cleared.
- The `v` read latency is fixed at 1 cycle. `v_rd_data` is ignored outside CALC.

## Structure
- Package `adex_pkg`:
  - state enum `adex_u_state_t` (IDLE, FETCH, CALC, WRITE, DONE);
  - default `DATA_W`/`FRAC_W` constants;
  - a saturating-narrow function `sat_narrow` shared with the `v` integrator.
- One sub-module, `adex_u_datapath`: a combinational `diff`/`u_next`/saturate datapath, so the FSM/register-file top stays separate and the datapath can be unit-tested.

## Test plan
All scenarios use default parameters, `FRAC_W` = 12, `dt` = 4096 (1.0) unless stated.
1. Rest: `v` = −70 for all neurons, no spikes, one sweep → every `u_out` = 0; `done` at cycle 49 after `start` (`N_NEURONS` = 16).
2. Spike: `spike_vec` bit 3 set, `v` = −70 → `u[3]` = 100, all others 0. Next sweep with no spike → `u[3]` = 0 (decay −100).
3. Drive: `v` = 2000 on neuron 0, `u` = 0 → `u_out` = 1 (2·2070 >>> 12 = 1).
4. Saturation: override `B_INC` = 20000, `dt` = 0, spike on neuron 5 for two sweeps → 20000, then 32767.
5. Rules and reset:
   - `start` pulsed while busy → ignored, exactly 16 `u_valid` strobes.
   - `rst` at the 7th `u_valid` → no `done`; next sweep at rest outputs 0 everywhere.
6. Clear: after test 2's spike, `u_clr` in IDLE → next sweep at rest, no spike: `u[3]` = 0. `u_clr` together with `start` → no sweep starts.
